// File: rtl/shape_storage_encoder_if.sv
// Shape-in / record-out handshake bundle between vertex capture, the encoder and object storage.
// Parameters must match the attached shape_storage_encoder instance.
interface shape_storage_encoder_if #(
  parameter int COORD_W = 10,
  parameter int NUM_PTS = 4,
  parameter int PARAM_W = 36,
  parameter int VEL_W   = 16
);
  logic                           valid_in;
  logic                           ready_out;
  logic [3+2*COORD_W*NUM_PTS-1:0] draw_props;
  logic                           ready_in;
  logic                           valid_out;
  logic                           is_static;
  logic [1:0]                     id_bits;
  logic [PARAM_W-1:0]             params;
  logic [COORD_W-1:0]             pos_x;
  logic [COORD_W-1:0]             pos_y;
  logic [VEL_W-1:0]               vel_x;
  logic [VEL_W-1:0]               vel_y;

  modport master (
    output valid_in, draw_props, ready_in,
    input  ready_out, valid_out, is_static, id_bits, params, pos_x, pos_y, vel_x, vel_y
  );

  modport slave (
    input  valid_in, draw_props, ready_in,
    output ready_out, valid_out, is_static, id_bits, params, pos_x, pos_y, vel_x, vel_y
  );
endinterface

// File: rtl/shape_storage_encoder.sv
// Converts one drawn shape into a physics storage record: serial min/max scan for
// rectangles, 2-bit-per-cycle restoring sqrt for circle radius, valid/ready on both sides.
module shape_storage_encoder #(
  parameter int COORD_W = 10,
  parameter int NUM_PTS = 4,
  parameter int PARAM_W = 36,
  parameter int VEL_W   = 16
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  shape_storage_encoder_if.slave bus
);
  localparam int SQ_W  = 2*COORD_W + 2;
  localparam int ITER  = SQ_W / 2;
  localparam int REM_W = ITER + 2;
  localparam int PTS_W = 2*COORD_W*NUM_PTS;
  localparam int IDX_W = $clog2(NUM_PTS);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {IDLE, SCAN, SQ_PREP, SQRT, OUT} state_t;

  function automatic logic [COORD_W-1:0] pt_x(input logic [PTS_W-1:0] p, input int i);
    return p[PTS_W-1-2*COORD_W*i -: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] pt_y(input logic [PTS_W-1:0] p, input int i);
    return p[PTS_W-1-2*COORD_W*i-COORD_W -: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [COORD_W-1:0] mid(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return COORD_W'(sum >> 1);
  endfunction

  function automatic logic [PARAM_W-1:0] pack2(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return PARAM_W'({a, b}) << (PARAM_W - 2*COORD_W);
  endfunction

  function automatic logic [PARAM_W-1:0] pack1(input logic [COORD_W-1:0] a);
    return PARAM_W'(a) << (PARAM_W - COORD_W);
  endfunction

  state_t             state, state_nxt;
  logic [PTS_W-1:0]   in_pts, pts;
  logic               in_static, accept, last_pt, last_iter;
  logic [1:0]         in_id;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] min_x, min_y, max_x, max_y, cen_x, cen_y, dx, dy;
  logic [COORD_W-1:0] cur_x, cur_y, fmin_x, fmin_y, fmax_x, fmax_y;
  logic [SQ_W-1:0]    sq_op;
  logic [REM_W-1:0]   rem, rem_nxt;
  logic [REM_W+1:0]   rem_t, trial;
  logic               sq_ge;
  logic [ITER-1:0]    root, root_nxt;
  logic               is_static_r;
  logic [1:0]         id_r;
  logic [PARAM_W-1:0] params_r;
  logic [COORD_W-1:0] pos_x_r, pos_y_r;

  assign in_pts    = bus.draw_props[PTS_W-1:0];
  assign in_id     = bus.draw_props[PTS_W+1:PTS_W];
  assign in_static = bus.draw_props[PTS_W+2];
  assign accept    = bus.valid_in && (state == IDLE);
  assign last_pt   = (idx == IDX_W'(NUM_PTS-1));
  assign last_iter = (cnt == CNT_W'(ITER-1));

  always_comb begin
    cur_x    = pt_x(pts, int'(idx));
    cur_y    = pt_y(pts, int'(idx));
    fmin_x   = (cur_x < min_x) ? cur_x : min_x;
    fmin_y   = (cur_y < min_y) ? cur_y : min_y;
    fmax_x   = (cur_x > max_x) ? cur_x : max_x;
    fmax_y   = (cur_y > max_y) ? cur_y : max_y;
    // One restoring-sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    rem_t    = {rem, sq_op[SQ_W-1 -: 2]};
    trial    = {2'b00, root, 2'b01};
    sq_ge    = (rem_t >= trial);
    rem_nxt  = sq_ge ? REM_W'(rem_t - trial) : REM_W'(rem_t);
    root_nxt = {root[ITER-2:0], sq_ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          case (in_id)
            2'b11:   state_nxt = SCAN;
            2'b01:   state_nxt = SQ_PREP;
            default: state_nxt = OUT;
          endcase
        end
      end
      SCAN:    if (last_pt) state_nxt = OUT;
      SQ_PREP: state_nxt = SQRT;
      SQRT:    if (last_iter) state_nxt = OUT;
      OUT:     if (bus.ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and record registers: cleared by reset so an aborted shape leaves nothing behind.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      is_static_r <= 1'b0;
      id_r        <= 2'b00;
      params_r    <= '0;
      pos_x_r     <= '0;
      pos_y_r     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            is_static_r <= in_static;
            id_r        <= in_id;
            idx         <= IDX_W'(1);
            if (in_id == 2'b00) begin
              pos_x_r  <= '0;
              pos_y_r  <= '0;
              params_r <= '0;
            end else if (in_id == 2'b10) begin
              pos_x_r  <= pt_x(in_pts, 0);
              pos_y_r  <= pt_y(in_pts, 0);
              params_r <= pack2(pt_x(in_pts, 1), pt_y(in_pts, 1));
            end
          end
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (last_pt) begin
            pos_x_r  <= fmin_x;
            pos_y_r  <= fmin_y;
            params_r <= pack2(fmax_x - fmin_x, fmax_y - fmin_y);
          end
        end
        SQ_PREP: cnt <= '0;
        SQRT: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            pos_x_r  <= cen_x;
            pos_y_r  <= cen_y;
            params_r <= pack1(root_nxt[ITER-1:1]);
          end
        end
        default: ;
      endcase
    end
  end

  // Working datapath: only meaningful while its state is active, so no reset.
  always_ff @(posedge clk_in) begin
    case (state)
      IDLE: begin
        if (accept) begin
          pts   <= in_pts;
          min_x <= pt_x(in_pts, 0);
          max_x <= pt_x(in_pts, 0);
          min_y <= pt_y(in_pts, 0);
          max_y <= pt_y(in_pts, 0);
          cen_x <= mid(pt_x(in_pts, 0), pt_x(in_pts, 1));
          cen_y <= mid(pt_y(in_pts, 0), pt_y(in_pts, 1));
          dx    <= abs_diff(pt_x(in_pts, 0), pt_x(in_pts, 1));
          dy    <= abs_diff(pt_y(in_pts, 0), pt_y(in_pts, 1));
        end
      end
      SCAN: begin
        min_x <= fmin_x;
        min_y <= fmin_y;
        max_x <= fmax_x;
        max_y <= fmax_y;
      end
      SQ_PREP: begin
        sq_op <= SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
        rem   <= '0;
        root  <= '0;
      end
      SQRT: begin
        sq_op <= sq_op << 2;
        rem   <= rem_nxt;
        root  <= root_nxt;
      end
      default: ;
    endcase
  end

  assign bus.ready_out = (state == IDLE) && rst_n_in;
  assign bus.valid_out = (state == OUT);
  assign bus.is_static = is_static_r;
  assign bus.id_bits   = id_r;
  assign bus.params    = params_r;
  assign bus.pos_x     = pos_x_r;
  assign bus.pos_y     = pos_y_r;
  assign bus.vel_x     = '0;
  assign bus.vel_y     = '0;
endmodule

// File: tb/tb_shape_storage_encoder.sv
// Bench for shape_storage_encoder: directed vector table, random shapes against a
// geometric reference model, backpressure and mid-circle reset sequences.
module tb_shape_storage_encoder;
  localparam int CW   = 10;
  localparam int NP   = 4;
  localparam int PW   = 36;
  localparam int VW   = 16;
  localparam int DPW  = 3 + 2*CW*NP;
  localparam int ITER = (2*CW + 2) / 2;

  typedef struct {
    bit          st;
    bit [1:0]    id;
    int          px[NP];
    int          py[NP];
    int          ex;
    int          ey;
    logic [PW-1:0] ep;
    int          el;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[8];

  shape_storage_encoder_if #(.COORD_W(CW), .NUM_PTS(NP), .PARAM_W(PW), .VEL_W(VW)) bus ();

  shape_storage_encoder #(.COORD_W(CW), .NUM_PTS(NP), .PARAM_W(PW), .VEL_W(VW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkp2(input int a, input int b);
    return PW'((longint'(a) << (PW - CW)) | (longint'(b) << (PW - 2*CW)));
  endfunction

  function automatic logic [PW-1:0] mkp1(input int a);
    return PW'(longint'(a) << (PW - CW));
  endfunction

  function automatic logic [DPW-1:0] pack(input bit st, input bit [1:0] id, input int px[NP], input int py[NP]);
    logic [DPW-1:0] d;
    d = '0;
    d[DPW-1] = st;
    d[DPW-2 -: 2] = id;
    for (int i = 0; i < NP; i++) begin
      d[DPW-4-2*CW*i -: CW]    = CW'(px[i]);
      d[DPW-4-2*CW*i-CW -: CW] = CW'(py[i]);
    end
    return d;
  endfunction

  // Reference model: record and latency straight from the geometric definition.
  task automatic model(input bit [1:0] id, input int px[NP], input int py[NP],
                       output int ex, output int ey, output logic [PW-1:0] ep, output int el);
    int mnx, mny, mxx, mxy, dx, dy, r;
    longint s;
    ex = 0; ey = 0; ep = '0; el = 1;
    case (id)
      2'b10: begin
        ex = px[0]; ey = py[0]; ep = mkp2(px[1], py[1]);
      end
      2'b11: begin
        mnx = px[0]; mxx = px[0]; mny = py[0]; mxy = py[0];
        for (int i = 1; i < NP; i++) begin
          if (px[i] < mnx) mnx = px[i];
          if (px[i] > mxx) mxx = px[i];
          if (py[i] < mny) mny = py[i];
          if (py[i] > mxy) mxy = py[i];
        end
        ex = mnx; ey = mny; ep = mkp2(mxx - mnx, mxy - mny); el = NP;
      end
      2'b01: begin
        dx = (px[0] > px[1]) ? px[0] - px[1] : px[1] - px[0];
        dy = (py[0] > py[1]) ? py[0] - py[1] : py[1] - py[0];
        s  = longint'(dx) * dx + longint'(dy) * dy;
        r  = 0;
        while (longint'(r + 1) * (r + 1) <= s) r++;
        ex = (px[0] + px[1]) / 2; ey = (py[0] + py[1]) / 2;
        ep = mkp1(r / 2); el = 2 + ITER;
      end
      default: ;
    endcase
  endtask

  task automatic set_vec(input int i, input bit st, input bit [1:0] id,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int x3, input int y3,
                         input int ex, input int ey, input logic [PW-1:0] ep, input int el);
    tbl[i].st = st; tbl[i].id = id;
    tbl[i].px[0] = x0; tbl[i].px[1] = x1; tbl[i].px[2] = x2; tbl[i].px[3] = x3;
    tbl[i].py[0] = y0; tbl[i].py[1] = y1; tbl[i].py[2] = y2; tbl[i].py[3] = y3;
    tbl[i].ex = ex; tbl[i].ey = ey; tbl[i].ep = ep; tbl[i].el = el;
  endtask

  task automatic run_shape(input string tag, input bit st, input bit [1:0] id,
                           input int px[NP], input int py[NP],
                           input int ex, input int ey, input logic [PW-1:0] ep, input int el);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.ready_out), 64'(1));
    bus.draw_props = pack(st, id, px, py);
    bus.valid_in   = 1'b1;
    bus.ready_in   = 1'b0;
    @(posedge clk);
    #1;
    bus.valid_in   = 1'b0;
    bus.draw_props = DPW'({$urandom, $urandom, $urandom});
    lat = 1;
    while (!bus.valid_out && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(el));
    check({tag, "_pos_x"}, 64'(bus.pos_x), 64'(ex));
    check({tag, "_pos_y"}, 64'(bus.pos_y), 64'(ey));
    check({tag, "_params"}, 64'(bus.params), 64'(ep));
    check({tag, "_static"}, 64'(bus.is_static), 64'(st));
    check({tag, "_id"}, 64'(bus.id_bits), 64'(id));
    check({tag, "_vel"}, 64'({bus.vel_x, bus.vel_y}), 64'(0));
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    check({tag, "_done_valid"}, 64'(bus.valid_out), 64'(0));
    check({tag, "_done_ready"}, 64'(bus.ready_out), 64'(1));
  endtask

  initial begin
    int px[NP], py[NP], ex, ey, el;
    logic [PW-1:0] ep;
    bit st;
    bit [1:0] id;

    bus.valid_in   = 1'b0;
    bus.ready_in   = 1'b0;
    bus.draw_props = '0;
    rst_n          = 1'b0;

    set_vec(0, 1'b1, 2'b10, 100, 200, 300, 50, 7, 8, 9, 10, 100, 200, mkp2(300, 50), 1);
    set_vec(1, 1'b0, 2'b11, 40, 90, 10, 20, 70, 15, 25, 60, 10, 15, mkp2(60, 75), 4);
    set_vec(2, 1'b0, 2'b01, 100, 100, 160, 180, 3, 4, 5, 6, 130, 140, mkp1(50), 13);
    set_vec(3, 1'b1, 2'b00, 5, 6, 7, 8, 9, 10, 11, 12, 0, 0, '0, 1);
    set_vec(4, 1'b1, 2'b01, 512, 512, 512, 512, 1, 2, 3, 4, 512, 512, '0, 13);
    set_vec(5, 1'b0, 2'b11, 33, 44, 33, 44, 33, 44, 33, 44, 33, 44, '0, 4);
    set_vec(6, 1'b0, 2'b01, 0, 0, 1023, 1023, 0, 0, 0, 0, 511, 511, mkp1(723), 13);
    set_vec(7, 1'b1, 2'b10, 1023, 0, 0, 1023, 0, 0, 0, 0, 1023, 0, mkp2(0, 1023), 1);

    #12;
    check("rst_valid", 64'(bus.valid_out), 64'(0));
    check("rst_ready", 64'(bus.ready_out), 64'(0));
    check("rst_record", 64'({bus.is_static, bus.id_bits, bus.pos_x, bus.pos_y}), 64'(0));
    check("rst_params", 64'(bus.params), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 64'(bus.ready_out), 64'(1));

    for (int i = 0; i < 8; i++)
      run_shape($sformatf("vec%0d", i), tbl[i].st, tbl[i].id, tbl[i].px, tbl[i].py,
                tbl[i].ex, tbl[i].ey, tbl[i].ep, tbl[i].el);

    for (int k = 0; k < 40; k++) begin
      st = 1'($urandom_range(0, 1));
      id = 2'($urandom_range(0, 3));
      for (int j = 0; j < NP; j++) begin
        px[j] = $urandom_range(0, 1023);
        py[j] = $urandom_range(0, 1023);
      end
      model(id, px, py, ex, ey, ep, el);
      run_shape($sformatf("rnd%0d", k), st, id, px, py, ex, ey, ep, el);
    end

    // Backpressure: record held for 5 cycles, queued shape taken on the first IDLE cycle.
    px = '{100, 300, 0, 0}; py = '{200, 50, 0, 0};
    @(negedge clk);
    bus.draw_props = pack(1'b1, 2'b10, px, py);
    bus.valid_in   = 1'b1;
    bus.ready_in   = 1'b0;
    @(posedge clk);
    #1;
    px = '{1, 3, 0, 0}; py = '{2, 4, 0, 0};
    bus.draw_props = pack(1'b0, 2'b10, px, py);
    check("bp_valid0", 64'(bus.valid_out), 64'(1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", c), 64'(bus.valid_out), 64'(1));
      check($sformatf("bp_hold%0d_ready", c), 64'(bus.ready_out), 64'(0));
      check($sformatf("bp_hold%0d_pos", c), 64'({bus.pos_x, bus.pos_y}), 64'({10'd100, 10'd200}));
      check($sformatf("bp_hold%0d_params", c), 64'(bus.params), 64'(mkp2(300, 50)));
      check($sformatf("bp_hold%0d_static", c), 64'(bus.is_static), 64'(1));
    end
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    check("bp_hs_valid", 64'(bus.valid_out), 64'(0));
    check("bp_hs_ready", 64'(bus.ready_out), 64'(1));
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    check("bp2_valid", 64'(bus.valid_out), 64'(1));
    check("bp2_pos", 64'({bus.pos_x, bus.pos_y}), 64'({10'd1, 10'd2}));
    check("bp2_params", 64'(bus.params), 64'(mkp2(3, 4)));
    check("bp2_static", 64'(bus.is_static), 64'(0));
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    check("bp2_done", 64'(bus.valid_out), 64'(0));

    // Reset during the 5th SQRT cycle of a circle.
    px = '{100, 160, 0, 0}; py = '{100, 180, 0, 0};
    @(negedge clk);
    bus.draw_props = pack(1'b1, 2'b01, px, py);
    bus.valid_in   = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(bus.valid_out), 64'(0));
    check("mr_ready", 64'(bus.ready_out), 64'(0));
    check("mr_static_id", 64'({bus.is_static, bus.id_bits}), 64'(0));
    check("mr_pos", 64'({bus.pos_x, bus.pos_y}), 64'(0));
    check("mr_params", 64'(bus.params), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_rel_ready", 64'(bus.ready_out), 64'(1));
    check("mr_rel_valid", 64'(bus.valid_out), 64'(0));
    px = '{100, 300, 0, 0}; py = '{200, 50, 0, 0};
    run_shape("mr_line", 1'b1, 2'b10, px, py, 100, 200, mkp2(300, 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
